// File: rtl/kgp_risc_sequencer.sv
// kgp_risc_sequencer: multi-cycle control FSM for the KGP-RISC core.
// Steps FETCH/DECODE/EXEC/MEM/WB/BRANCH/HALT and drives datapath load enables.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   opcode[5:0]       IR opcode field, sampled in DECODE only
//   alu_flag[2:0]     ZNC flags (branch resolution happens outside)
//   mem_ready         data memory completes the access this cycle
//   ir_load, pc_load  IR / PC load enables
//   branch_ctrl[1:0]  code for the branching mechanism (11 = pc+1)
//   flag_load         latch ALU ZNC into the flag register
//   reg_write         register file write enable
//   link_write        write ra with the return address (bl)
//   alu_src_imm       ALU operand B is the sign-extended immediate
//   mem_read/write    data memory requests, held until mem_ready
//   illegal           sticky undefined-opcode indication
//   halted            FSM is parked in HALT
//   retired[CNT_W]    wrapping count of completed instructions
//   state[2:0]        current state for debug
module kgp_risc_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [2:0]       alu_flag,
   input  logic             mem_ready,
   output logic             ir_load,
   output logic             pc_load,
   output logic [1:0]       branch_ctrl,
   output logic             flag_load,
   output logic             reg_write,
   output logic             link_write,
   output logic             alu_src_imm,
   output logic             mem_read,
   output logic             mem_write,
   output logic             illegal,
   output logic             halted,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_BRANCH = 3'd5,
      S_HALT   = 3'd6,
      S_BAD    = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_NONE,
      C_RALU,
      C_IALU,
      C_LOAD,
      C_STORE,
      C_BR0,
      C_BR1,
      C_BL,
      C_HALT,
      C_ILL
   } cls_t;

   state_t           state_q, state_d;
   cls_t             cls_q, cls_d;
   cls_t             dec_cls;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] ret_q, ret_d;

   // Flags are consumed by the external branching mechanism only.
   logic unused_flags;
   assign unused_flags = ^alu_flag;

   always_comb begin
      case (opcode)
         6'b000000: dec_cls = C_RALU;
         6'b000001: dec_cls = C_IALU;
         6'b000010: dec_cls = C_LOAD;
         6'b000011: dec_cls = C_STORE;
         6'b000100: dec_cls = C_BR0;
         6'b000101: dec_cls = C_BR1;
         6'b000110: dec_cls = C_BL;
         6'b111111: dec_cls = C_HALT;
         default:   dec_cls = C_ILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cls_q   <= C_NONE;
         ill_q   <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         ill_q   <= ill_d;
         ret_q   <= ret_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      ill_d       = ill_q;
      ret_d       = ret_q;
      ir_load     = 1'b0;
      pc_load     = 1'b0;
      branch_ctrl = 2'b11;
      flag_load   = 1'b0;
      reg_write   = 1'b0;
      link_write  = 1'b0;
      alu_src_imm = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;

      case (state_q)
         S_FETCH: begin
            ir_load = 1'b1;
            state_d = S_DECODE;
         end

         S_DECODE: begin
            cls_d = dec_cls;
            case (dec_cls)
               C_RALU, C_IALU, C_LOAD, C_STORE:
                  state_d = S_EXEC;
               C_BR0, C_BR1, C_BL:
                  state_d = S_BRANCH;
               C_HALT:
                  state_d = S_HALT;
               default: begin
                  ill_d   = 1'b1;
                  state_d = S_WB;
               end
            endcase
         end

         S_EXEC: begin
            alu_src_imm = (cls_q == C_IALU) ||
                          (cls_q == C_LOAD) ||
                          (cls_q == C_STORE);
            flag_load   = (cls_q == C_RALU) ||
                          (cls_q == C_IALU);
            if (cls_q == C_LOAD || cls_q == C_STORE)
               state_d = S_MEM;
            else
               state_d = S_WB;
         end

         S_MEM: begin
            if (cls_q == C_LOAD) begin
               mem_read = 1'b1;
               if (mem_ready)
                  state_d = S_WB;
            end else if (cls_q == C_STORE) begin
               mem_write = 1'b1;
               // A store retires straight out of MEM, so the PC
               // update is qualified by ready to keep it one-shot.
               if (mem_ready) begin
                  pc_load = 1'b1;
                  ret_d   = ret_q + CNT_W'(1);
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_FETCH;
            end
         end

         S_WB: begin
            reg_write = (cls_q == C_RALU) ||
                        (cls_q == C_IALU) ||
                        (cls_q == C_LOAD);
            pc_load   = 1'b1;
            ret_d     = ret_q + CNT_W'(1);
            state_d   = S_FETCH;
         end

         S_BRANCH: begin
            pc_load = 1'b1;
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
            case (cls_q)
               C_BR0: branch_ctrl = 2'b00;
               C_BR1: branch_ctrl = 2'b01;
               C_BL: begin
                  branch_ctrl = 2'b10;
                  link_write  = 1'b1;
                  reg_write   = 1'b1;
               end
               default: branch_ctrl = 2'b11;
            endcase
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign illegal = ill_q;
   assign halted  = (state_q == S_HALT);
   assign retired = ret_q;
   assign state   = state_q;

endmodule
